dmem_mmio: RTL and testbench

//  Memory-stage slave of the pipelined RV32 core. Consumes the core's M-stage bus
//  (MemWriteM, ALUResultM, WriteData, StoreType) and returns ReadDataM in the same cycle.

---
 rtl/dmem_mmio.sv | 216 +++++++++++++++++++++
 tb/tb_dmem_mmio.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio: memory-stage slave for the pipelined RV32 core.
// Word-organised data RAM with byte-lane stores, plus a 32-byte MMIO page:
// a 64-bit cycle counter, a byte TX FIFO with a valid/ready drain port and
// a status register. Reads are combinational and return the aligned word.
//
// Optional feature: define DMEM_MISALIGN_TRAP_EN to suppress misaligned
// half/word stores, raise the sticky misalign_err flag and capture the
// faulting address in MADDR. With it undefined, misaligned stores use the
// normal lane rule, misalign_err is 0 and MADDR reads 0.
//
// Drain handshake: tx_valid is high whenever the FIFO holds a byte and
// tx_data shows the head entry. The head is consumed at a posedge where
// tx_valid & tx_ready are both high; while tx_valid & !tx_ready the head
// and tx_data hold steady.
//
// Observable state for checkers: the FIFO state is visible through STATUS
// (full, empty, count, ovf) and through tx_valid/tx_data.

module dmem_mmio #(
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteData,
  input  logic [1:0]  StoreType,
  output logic [31:0] ReadDataM,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        misalign_err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          FW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [FW:0] FIFO_FULL = (FW + 1)'(FIFO_DEPTH);

  // MMIO word offsets within the page
  localparam logic [2:0] OFF_CYC_LO = 3'd0;
  localparam logic [2:0] OFF_CYC_HI = 3'd1;
  localparam logic [2:0] OFF_TXDATA = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_MADDR  = 3'd4;

  // Storage
  logic [31:0]   r_mem [DEPTH];
  logic [63:0]   r_cyc;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_rd_ptr;
  logic [FW-1:0] r_wr_ptr;
  logic [FW:0]   r_count;
  logic          r_ovf;

  // Address decode
  logic          w_is_ram;
  logic          w_is_mmio;
  logic [AW-1:0] w_word_idx;
  logic [2:0]    w_mmio_off;
  logic [1:0]    w_lane;

  assign w_is_ram   = (ALUResultM < RAM_BYTES);
  assign w_is_mmio  = (ALUResultM[31:5] == MMIO_BASE[31:5]);
  assign w_word_idx = ALUResultM[AW+1:2];
  assign w_mmio_off = ALUResultM[4:2];
  assign w_lane     = ALUResultM[1:0];

  // Store qualification: stores in the reset cycle never take effect
  logic        w_store_ok;
  logic [31:0] w_maddr;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic        w_misaligned;
  logic        w_trap;
  logic        r_mis;
  logic [31:0] r_maddr;

  assign w_misaligned = ((StoreType == 2'b01) && ALUResultM[0]) ||
                        ((StoreType == 2'b00) && (ALUResultM[1:0] != 2'b00));
  assign w_store_ok   = MemWriteM & ~reset & ~w_misaligned;
  assign w_trap       = MemWriteM & ~reset & w_misaligned;
  assign w_maddr      = r_maddr;
  assign misalign_err = r_mis;
`else
  assign w_store_ok   = MemWriteM & ~reset;
  assign w_maddr      = 32'h0;
  assign misalign_err = 1'b0;
`endif

  // Byte enables and lane-replicated write data; lanes past 3 are dropped
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  // Derive lane enables from store size and low address bits
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = WriteData;
    case (StoreType)
      2'b00: begin
        w_be    = 4'b1111 << w_lane;
        w_wdata = WriteData;
      end
      2'b01: begin
        w_be    = 4'b0011 << w_lane;
        w_wdata = {2{WriteData[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{WriteData[7:0]}};
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = WriteData;
      end
    endcase
  end

  // MMIO accepts word stores only
  logic w_mmio_wr;
  logic w_push;
  logic w_clr_ovf;

  assign w_mmio_wr = w_store_ok & w_is_mmio & (StoreType == 2'b00);
  assign w_push    = w_mmio_wr & (w_mmio_off == OFF_TXDATA);
  assign w_clr_ovf = w_mmio_wr & (w_mmio_off == OFF_STATUS);

  // FIFO flags and handshake
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_do_push;
  logic [2:0] w_count3;

  assign w_full    = (r_count == FIFO_FULL);
  assign w_empty   = (r_count == '0);
  assign tx_valid  = ~w_empty;
  assign tx_data   = r_fifo[r_rd_ptr];
  assign w_pop     = tx_valid & tx_ready;
  // A push into a full FIFO still lands when the head leaves the same cycle
  assign w_do_push = w_push & (~w_full | w_pop);
  assign w_count3  = 3'(r_count);

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (w_store_ok && w_is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_word_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // Free-running 64-bit cycle counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) r_cyc <= 64'h0;
    else       r_cyc <= r_cyc + 64'h1;
  end

  // TX FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= 8'h00;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_fifo[r_wr_ptr] <= WriteData[7:0];
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_clr_ovf)             r_ovf <= 1'b0;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  // Sticky misaligned-store flag with faulting address capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mis   <= 1'b0;
      r_maddr <= 32'h0;
    end else if (w_trap) begin
      r_mis   <= 1'b1;
      r_maddr <= ALUResultM;
    end else if (w_mmio_wr && (w_mmio_off == OFF_MADDR)) begin
      r_mis   <= 1'b0;
    end
  end
`endif

  // Combinational read of the aligned word; unmapped space reads 0
  always_comb begin
    ReadDataM = 32'h0;
    if (w_is_ram) begin
      ReadDataM = r_mem[w_word_idx];
    end else if (w_is_mmio) begin
      case (w_mmio_off)
        OFF_CYC_LO: ReadDataM = r_cyc[31:0];
        OFF_CYC_HI: ReadDataM = r_cyc[63:32];
        OFF_STATUS: ReadDataM = {26'h0, r_ovf, w_count3, w_empty, w_full};
        OFF_MADDR:  ReadDataM = w_maddr;
        default:    ReadDataM = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed bench for dmem_mmio with hand-computed expectations.
// Build with or without DMEM_MISALIGN_TRAP_EN; expectations follow the define.

module tb_dmem_mmio;

  localparam logic [31:0] BASE   = 32'hFFFF0000;
  localparam logic [31:0] CYC_LO = BASE + 32'h00;
  localparam logic [31:0] CYC_HI = BASE + 32'h04;
  localparam logic [31:0] TXDATA = BASE + 32'h08;
  localparam logic [31:0] STATUS = BASE + 32'h0C;
  localparam logic [31:0] MADDR  = BASE + 32'h10;
  localparam logic [1:0]  ST_W   = 2'b00;
  localparam logic [1:0]  ST_H   = 2'b01;
  localparam logic [1:0]  ST_B   = 2'b10;
  localparam logic [1:0]  ST_R   = 2'b11;

  logic        clk;
  logic        reset;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteData;
  logic [1:0]  StoreType;
  logic [31:0] ReadDataM;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        misalign_err;

  int n_total = 0;
  int n_bad   = 0;

  dmem_mmio dut (
    .clk          (clk),
    .reset        (reset),
    .MemWriteM    (MemWriteM),
    .ALUResultM   (ALUResultM),
    .WriteData    (WriteData),
    .StoreType    (StoreType),
    .ReadDataM    (ReadDataM),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .misalign_err (misalign_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One store cycle: drive at a negedge, takes effect at the following posedge
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] st);
    @(negedge clk);
    ALUResultM = addr;
    WriteData  = data;
    StoreType  = st;
    MemWriteM  = 1'b1;
    @(negedge clk);
    MemWriteM  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    MemWriteM  = 1'b0;
    ALUResultM = addr;
    #1;
    chk(tag, ReadDataM, exp);
  endtask

  initial begin
    reset      = 1'b1;
    MemWriteM  = 1'b0;
    ALUResultM = 32'h0;
    WriteData  = 32'h0;
    StoreType  = ST_W;
    tx_ready   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
    ALUResultM = STATUS; #1;
    chk("rst_status", ReadDataM, 32'h0000_0002);
    ALUResultM = CYC_LO; #1;
    chk("rst_cyc_lo", ReadDataM, 32'h0);
    reset = 1'b0;

    // Counter: 10 posedges after release
    repeat (10) @(negedge clk);
    ALUResultM = CYC_LO; #1;
    chk("cyc_lo_10", ReadDataM, 32'd10);
    ALUResultM = CYC_HI; #1;
    chk("cyc_hi_0", ReadDataM, 32'd0);
    repeat (5) @(negedge clk);
    ALUResultM = CYC_LO; #1;
    chk("cyc_lo_15", ReadDataM, 32'd15);
    // Counter write is ignored: two more cycles pass during the store
    store(CYC_LO, 32'h0, ST_W);
    ALUResultM = CYC_LO; #1;
    chk("cyc_lo_nowrite", ReadDataM, 32'd17);

    // RAM: word then byte overlay
    store(32'h10, 32'hDEADBEEF, ST_W);
    rd_chk("ram_word", 32'h10, 32'hDEADBEEF);
    store(32'h11, 32'h00000055, ST_B);
    rd_chk("ram_byte", 32'h10, 32'hDEAD55EF);
    rd_chk("ram_byte_unal_rd", 32'h13, 32'hDEAD55EF);

    // Half at lanes 2,3
    store(32'h20, 32'h00000000, ST_W);
    store(32'h22, 32'h0000A1B2, ST_H);
    rd_chk("ram_half_hi", 32'h20, 32'hA1B20000);
    store(32'h24, 32'h00000000, ST_W);
    store(32'h24, 32'h0000C3D4, ST_H);
    rd_chk("ram_half_lo", 32'h24, 32'h0000C3D4);

    // Odd half: lanes 1,2 from the replicated half, or suppressed by trap
    store(32'h30, 32'h11223344, ST_W);
    store(32'h31, 32'h0000BEEF, ST_H);
`ifdef DMEM_MISALIGN_TRAP_EN
    rd_chk("ram_half_odd", 32'h30, 32'h11223344);
    rd_chk("maddr_half_odd", MADDR, 32'h00000031);
`else
    rd_chk("ram_half_odd", 32'h30, 32'h11EFBE44);
`endif

    // Reserved store type never writes
    store(32'h40, 32'h89ABCDEF, ST_W);
    store(32'h40, 32'h00000000, ST_R);
    rd_chk("ram_reserved", 32'h40, 32'h89ABCDEF);

    // Last RAM word and the first address past RAM
    store(32'hFFC, 32'h0BADF00D, ST_W);
    rd_chk("ram_last", 32'hFFC, 32'h0BADF00D);
    store(32'h1000, 32'hFFFFFFFF, ST_W);
    rd_chk("beyond_ram", 32'h1000, 32'h0);
    rd_chk("unmapped_hi", 32'h80000000, 32'h0);
    rd_chk("mmio_unused", BASE + 32'h14, 32'h0);
    rd_chk("below_mmio", BASE - 32'h4, 32'h0);
    rd_chk("ram_first_intact", 32'h0FFC, 32'h0BADF00D);

    // FIFO fill with overflow
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) store(TXDATA, 32'h100 + 32'(i), ST_W);
    rd_chk("status_ovf", STATUS, 32'h0000_0031);
    rd_chk("txdata_rd0", TXDATA, 32'h0);
    chk("head_stable", {24'h0, tx_data}, 32'h01);
    store(STATUS, 32'h0, ST_B);
    rd_chk("status_subword_noclr", STATUS, 32'h0000_0031);
    store(STATUS, 32'h0, ST_W);
    rd_chk("status_clr", STATUS, 32'h0000_0011);

    // Drain in order
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("drain_valid%0d", i), {31'h0, tx_valid}, 32'h1);
      chk($sformatf("drain_data%0d", i), {24'h0, tx_data}, 32'(i));
      @(negedge clk);
    end
    #1;
    chk("drained_valid", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    rd_chk("status_empty", STATUS, 32'h0000_0002);
    store(TXDATA, 32'h77, ST_B);
    rd_chk("txdata_subword", STATUS, 32'h0000_0002);

    // Push and pop while full: count holds, no overflow
    for (int i = 0; i < 4; i++) store(TXDATA, 32'h0A + 32'(i), ST_W);
    @(negedge clk);
    ALUResultM = TXDATA;
    WriteData  = 32'h0E;
    StoreType  = ST_W;
    MemWriteM  = 1'b1;
    tx_ready   = 1'b1;
    @(negedge clk);
    MemWriteM  = 1'b0;
    tx_ready   = 1'b0;
    rd_chk("status_pushpop", STATUS, 32'h0000_0011);
    chk("head_after_pushpop", {24'h0, tx_data}, 32'h0B);
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("pp_data%0d", i), {24'h0, tx_data}, 32'h0B + 32'(i));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    #1;
    chk("pp_drained", {31'h0, tx_valid}, 32'h0);

    // Misaligned word store to 0x06
    store(32'h04, 32'h01020304, ST_W);
    store(32'h06, 32'hAABBCCDD, ST_W);
`ifdef DMEM_MISALIGN_TRAP_EN
    rd_chk("mis_ram", 32'h04, 32'h01020304);
    chk("mis_flag", {31'h0, misalign_err}, 32'h1);
    rd_chk("mis_maddr", MADDR, 32'h00000006);
    store(MADDR, 32'h0, ST_W);
    #1;
    chk("mis_clr", {31'h0, misalign_err}, 32'h0);
`else
    rd_chk("mis_ram", 32'h04, 32'hAABB0304);
    chk("mis_flag", {31'h0, misalign_err}, 32'h0);
    rd_chk("mis_maddr", MADDR, 32'h0);
`endif

    // Reset mid-drain, with a store in the reset cycle
    store(32'h50, 32'hCAFEF00D, ST_W);
    store(TXDATA, 32'h21, ST_W);
    store(TXDATA, 32'h22, ST_W);
    @(negedge clk);
    reset      = 1'b1;
    ALUResultM = 32'h50;
    WriteData  = 32'h12345678;
    StoreType  = ST_W;
    MemWriteM  = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    MemWriteM  = 1'b0;
    #1;
    chk("rst2_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst2_tx_data", {24'h0, tx_data}, 32'h0);
    rd_chk("rst2_status", STATUS, 32'h0000_0002);
    rd_chk("rst2_store_ignored", 32'h50, 32'hCAFEF00D);
    rd_chk("rst2_ram_kept", 32'h10, 32'hDEAD55EF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
